irq_ctrl_wb: RTL and testbench
==============================

# irq_ctrl_wb

Wishbone-slave interrupt controller placed directly upstream of the CPU's `interrupt` input. It collects the SoC interrupt sources:

- debounced push-buttons
- timer tick
- UART `received`
- address exception

It detects edges or levels per source and latches pending bits. The CPU can read and mask them, software-trigger them, and clear them through one slave port on `intercon`. The registered, masked vector drives the CPU's 32-bit `interrupt` bus.

## Interface

Parameters:
- `NUM_SRC`, 6: number of interrupt sources (1..32); source bit i maps to `irq_o[i]`.
- `AW`, 32: Wishbone address width.
- `DW`, 32: Wishbone data width (fixed at 32).

Ports:
- `wb_clk_i`  in  1: single clock for all logic.
- `wb_rst_i`  in  1: reset, synchronous, active-high.
- `wb_adr_i`  in  AW: byte address; only `[4:2]` decoded.
- `wb_dat_i`  in  DW: write data.
- `wb_sel_i`  in  4: byte lane enables for writes.
- `wb_we_i`  in  1: write enable.
- `wb_stb_i`  in  1: strobe.
- `wb_cyc_i`  in  1: cycle.
- `wb_dat_o`  out  DW: read data, valid with `wb_ack_o`.
- `wb_ack_o`  out  1: acknowledge.
- `wb_err_o`  out  1: error for unmapped offsets.
- `wb_rty_o`  out  1: tied 0.
- `irq_src_i`  in  NUM_SRC: raw sources, synchronous to `wb_clk_i`.
- `irq_o`  out  32: `{(32-NUM_SRC)'b0, PEND & MASK}`, registered; feeds CPU `interrupt`.
- `irq_any_o`  out  1: OR-reduce of `irq_o`, registered.

## Operation

Registers are 32 bits wide, word offsets. Bits at or above NUM_SRC read 0 and ignore writes.
- 0x00 PEND (RO): pending bits.
- 0x04 MASK (RW): 1 = enabled. Reset 0.
- 0x08 EDGE (RW): 1 = rising-edge mode, 0 = level mode. Reset all ones.
- 0x0C CLR (WO, W1C): a 1 clears the PEND bit. Reads 0.
- 0x10 RAW (RO): value of `src_q`.
- 0x14 SET (WO, W1S): a 1 sets the PEND bit (software trigger). Reads 0.
- 0x18–0x1C: unmapped.

Input stage:
- `src_q <= irq_src_i; src_d <= src_q`.
- Event is `EDGE ? (src_q & ~src_d) : src_q`.

PEND update per bit, in priority order:
- 1. Reset: clear.
- 2. Event, or SET write with 1: set.
- 3. CLR write with 1: clear.
- 4. Otherwise: hold.

Consequences:
- An event and a CLR in the same cycle leave the bit set.
- In level mode a bit cannot stay cleared while its source is high.

Other rules:
- Event detection is independent of MASK. Masked sources still accumulate PEND.
- Writes honour `wb_sel_i` per byte lane, for MASK, EDGE, CLR and SET.
- `wb_cti_i` and `wb_bte_i` are not used. Every access is a classic single cycle.

## Timing

Wishbone handshake:
- For a mapped access with `wb_cyc_i & wb_stb_i & ~wb_ack_o`, `wb_ack_o` is high for exactly one cycle on the next edge.
- A write is committed at that same edge.
- `wb_dat_o` is loaded at that same edge. It holds the register value before any same-edge update.
- The master must hold `stb` until ack. Back-to-back accesses therefore take 2 cycles each.
- An unmapped offset pulses `wb_err_o` instead of ack for one cycle, with no side effects and `wb_dat_o` = 0.
- `wb_ack_o` and `wb_err_o` are never high together.

Source-to-output latency (edge mode):
- Source high before edge k → `src_q` at k → PEND at k+1 → `irq_o`/`irq_any_o` at k+2.
- A source pulse of one cycle is captured.
- A source held high produces exactly one event.

Register-to-output latency:
- A MASK, SET or CLR write committed at edge k is visible on `irq_o` at k+1.

Reset:
- All of these go to 0: `wb_ack_o`, `wb_err_o`, `wb_dat_o`, `irq_o`, `irq_any_o`, PEND, MASK, `src_q`, `src_d`.
- EDGE resets to all ones.
- Reset asserted during a bus access aborts it: no ack, no write.
- A source held high across reset release produces one edge event 2 cycles after release.

## Test plan

- Reset, then read MASK, EDGE and PEND → 0x0, 0x3F and 0x0; `irq_o` = 0.
- MASK=0x3F, EDGE default, pulse `irq_src_i[2]` for 1 cycle at edge k → `irq_o` = 0x04 at k+2. Source held high 100 cycles → PEND still 0x04 with no re-trigger after CLR 0x04.
- EDGE=0x00, MASK=0x01, hold src0 high, write CLR=0x01 → PEND bit0 reads 1 again. Drop src0, then CLR → PEND 0, `irq_o` 0.
- MASK=0x00, pulse src4 → PEND=0x10, `irq_o`=0. Then MASK=0x10 → `irq_o`=0x10 one cycle after the ack.
- Src1 edge event on the same edge as a CLR=0x02 commit → PEND bit1 = 1. SET=0x20 with `wb_sel_i`=4'b0000 → no change. SET=0x20 with `wb_sel_i`=4'b0001 → PEND bit5 = 1.
- Access offset 0x1C → single-cycle `wb_err_o`, no ack. Assert `wb_rst_i` during a pending write to MASK → MASK = 0, no ack.

Source files
------------

// File: rtl/irq_ctrl_wb.sv
// -----------------------------------------------------------------------------
// irq_ctrl_wb
//
// This is a Wishbone-slave interrupt controller that sits in front of the CPU
// `interrupt` input. It does three jobs:
//   - It detects events on each source. Each source is set to rising-edge or
//     level mode.
//   - It latches those events into pending bits (PEND).
//   - It drives the registered vector PEND & MASK onto the CPU interrupt bus.
//
// Register map (word offsets, decoded from wb_adr_i[4:2]):
//   0x00 PEND  RO   pending bits
//   0x04 MASK  RW   1 = source enabled onto irq_o, reset 0
//   0x08 EDGE  RW   1 = rising-edge mode, 0 = level mode, reset all ones
//   0x0C CLR   WO   write 1 to clear a pending bit, reads 0
//   0x10 RAW   RO   synchronised source value (src_q)
//   0x14 SET   WO   write 1 to set a pending bit (software trigger), reads 0
//   0x18-0x1C       unmapped, answered with wb_err_o
// Bits at or above NUM_SRC read 0 and ignore writes.
//
// Ports:
//   wb_clk_i, wb_rst_i   clock, synchronous active-high reset
//   wb_adr_i ... wb_cyc_i Wishbone classic slave inputs
//   wb_dat_o, wb_ack_o   read data and acknowledge
//   wb_err_o             error for unmapped offsets
//   wb_rty_o             tied 0
//   irq_src_i            raw interrupt sources, already synchronous to wb_clk_i
//   irq_o                registered PEND & MASK, zero-extended to 32 bits
//   irq_any_o            registered OR of irq_o
//
// Handshake: every access is a classic single cycle. A request is
// cyc & stb while neither ack nor err is already high. Such a request is
// answered at the next clock edge with a one-cycle ack (mapped offset) or a
// one-cycle err (unmapped offset). A write and the read-data capture both
// happen at that answering edge. Read data shows the register value from
// before any update made at that same edge. The master holds stb until it
// sees ack or err.
// -----------------------------------------------------------------------------
module irq_ctrl_wb #(
    parameter int NUM_SRC = 6,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [AW-1:0]      wb_adr_i,
    input  logic [DW-1:0]      wb_dat_i,
    input  logic [3:0]         wb_sel_i,
    input  logic               wb_we_i,
    input  logic               wb_stb_i,
    input  logic               wb_cyc_i,
    output logic [DW-1:0]      wb_dat_o,
    output logic               wb_ack_o,
    output logic               wb_err_o,
    output logic               wb_rty_o,
    input  logic [NUM_SRC-1:0] irq_src_i,
    output logic [31:0]        irq_o,
    output logic               irq_any_o
);

    localparam logic [2:0] OFF_PEND = 3'd0;
    localparam logic [2:0] OFF_MASK = 3'd1;
    localparam logic [2:0] OFF_EDGE = 3'd2;
    localparam logic [2:0] OFF_CLR  = 3'd3;
    localparam logic [2:0] OFF_RAW  = 3'd4;
    localparam logic [2:0] OFF_SET  = 3'd5;

    // Zero-extend a per-source vector to the 32-bit register and bus width.
    // Written this way so that it also works when NUM_SRC is 32.
    function automatic logic [31:0] zext(input logic [NUM_SRC-1:0] v);
        logic [31:0] r;
        r = '0;
        r[NUM_SRC-1:0] = v;
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [NUM_SRC-1:0] pend_q;
    logic [NUM_SRC-1:0] mask_q;
    logic [NUM_SRC-1:0] edge_q;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] src_d;

    // -------------------------------------------------------------------------
    // Bus decode
    // -------------------------------------------------------------------------
    logic               access;
    logic               mapped;
    logic               do_write;
    logic [2:0]         off;
    logic [31:0]        lanes;
    logic [NUM_SRC-1:0] lane_bits;
    logic [NUM_SRC-1:0] wbits;
    logic [31:0]        rdata;

    always_comb begin
        // A request that was already answered is not served again. This keeps
        // ack and err to one-cycle pulses while the master still holds stb.
        access    = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
        off       = wb_adr_i[4:2];
        mapped    = (off <= OFF_SET);
        do_write  = access & mapped & wb_we_i;
        lanes     = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                     {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
        lane_bits = lanes[NUM_SRC-1:0];
        // Data bits whose byte lane is enabled.
        wbits     = wb_dat_i[NUM_SRC-1:0] & lane_bits;
    end

    // Read mux. This is sampled into wb_dat_o at the answering edge, so it
    // shows the value from before any write made at that same edge.
    always_comb begin
        rdata = '0;
        case (off)
            OFF_PEND: rdata = zext(pend_q);
            OFF_MASK: rdata = zext(mask_q);
            OFF_EDGE: rdata = zext(edge_q);
            OFF_RAW:  rdata = zext(src_q);
            default:  rdata = '0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Event detection and next-state
    // -------------------------------------------------------------------------
    logic [NUM_SRC-1:0] ev;
    logic [NUM_SRC-1:0] set_bits;
    logic [NUM_SRC-1:0] clr_bits;
    logic [NUM_SRC-1:0] pend_next;
    logic [NUM_SRC-1:0] mask_next;
    logic [NUM_SRC-1:0] edge_next;
    logic [NUM_SRC-1:0] irq_vec;

    always_comb begin
        // Edge mode: rising edge of the synchronised source.
        // Level mode: the synchronised source itself.
        // MASK does not affect event detection.
        ev       = (edge_q & src_q & ~src_d) | (~edge_q & src_q);

        set_bits = (do_write && off == OFF_SET) ? wbits : '0;
        clr_bits = (do_write && off == OFF_CLR) ? wbits : '0;

        // Setting wins over clearing. A CLR in the same cycle as an event
        // leaves the bit set. In level mode a high source keeps the bit set.
        pend_next = ev | set_bits | (pend_q & ~clr_bits);

        mask_next = mask_q;
        if (do_write && off == OFF_MASK) begin
            mask_next = (mask_q & ~lane_bits) | wbits;
        end

        edge_next = edge_q;
        if (do_write && off == OFF_EDGE) begin
            edge_next = (edge_q & ~lane_bits) | wbits;
        end

        // The output stage registers the current PEND & MASK. A MASK, SET or
        // CLR write committed at edge k therefore shows on irq_o at k+1.
        irq_vec = pend_q & mask_q;
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            pend_q    <= '0;
            mask_q    <= '0;
            edge_q    <= '1;
            src_q     <= '0;
            src_d     <= '0;
            irq_o     <= '0;
            irq_any_o <= 1'b0;
            wb_ack_o  <= 1'b0;
            wb_err_o  <= 1'b0;
            wb_dat_o  <= '0;
        end else begin
            src_q     <= irq_src_i;
            src_d     <= src_q;
            pend_q    <= pend_next;
            mask_q    <= mask_next;
            edge_q    <= edge_next;
            irq_o     <= zext(irq_vec);
            irq_any_o <= |irq_vec;
            wb_ack_o  <= access & mapped;
            wb_err_o  <= access & ~mapped;
            if (access) begin
                wb_dat_o <= mapped ? rdata : '0;
            end
        end
    end

    assign wb_rty_o = 1'b0;

    // Address bits outside [4:2], data bits above NUM_SRC and the upper lane
    // enables do not affect behaviour. They are reduced here so that they
    // are not left dangling.
    logic unused_ok;
    assign unused_ok = ^{wb_adr_i, wb_dat_i, lanes};

endmodule

// File: tb/tb_irq_ctrl_wb.sv
// -----------------------------------------------------------------------------
// tb_irq_ctrl_wb
//
// This is the self-checking bench for irq_ctrl_wb with NUM_SRC = 6.
// A per-source behavioural model advances on every rising clock edge.
// A compare process checks the DUT outputs against the model on every
// falling edge. Directed scenarios pin the model with literal expectations.
// A randomized phase follows.
// -----------------------------------------------------------------------------
module tb_irq_ctrl_wb;

    localparam int N = 6;

    // ---------------------------------------------------------------- clock/reset
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- DUT signals
    logic [31:0] wb_adr = '0;
    logic [31:0] wb_dat = '0;
    logic [3:0]  wb_sel = '0;
    logic        wb_we  = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_cyc = 1'b0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;
    logic [N-1:0] src = '0;
    logic [31:0] irq_o;
    logic        irq_any_o;

    int tests = 0;
    int fails = 0;

    irq_ctrl_wb #(.NUM_SRC(N), .AW(32), .DW(32)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wb_adr_i  (wb_adr),
        .wb_dat_i  (wb_dat),
        .wb_sel_i  (wb_sel),
        .wb_we_i   (wb_we),
        .wb_stb_i  (wb_stb),
        .wb_cyc_i  (wb_cyc),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_o  (wb_ack_o),
        .wb_err_o  (wb_err_o),
        .wb_rty_o  (wb_rty_o),
        .irq_src_i (src),
        .irq_o     (irq_o),
        .irq_any_o (irq_any_o)
    );

    // ---------------------------------------------------------------- model
    // Per-source bit arrays. Each source follows the rules on its own:
    // the synchroniser history, event detection, and set/clear priority.
    bit m_pend [N];
    bit m_mask [N];
    bit m_edge [N];
    bit m_sq   [N];
    bit m_sd   [N];
    bit [31:0] m_irq;
    bit        m_any;
    bit        m_ack;
    bit        m_err;
    bit [31:0] m_dat;

    function automatic bit [31:0] pack_arr(input bit a [N]);
        bit [31:0] r = 0;
        for (int i = 0; i < N; i++) r[i] = a[i];
        return r;
    endfunction

    always @(posedge clk) begin
        bit        req;
        int        off;
        bit [31:0] n_irq;
        bit        n_pend [N];
        bit        n_mask [N];
        bit        n_edge [N];
        bit        evt;
        bit        wr_bit;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 0; m_mask[i] = 0; m_edge[i] = 1;
                m_sq[i] = 0; m_sd[i] = 0;
            end
            m_irq = 0; m_any = 0; m_ack = 0; m_err = 0; m_dat = 0;
        end else begin
            req = wb_cyc && wb_stb && !m_ack && !m_err;
            off = int'(wb_adr[4:2]);
            // The outputs take the pre-edge state.
            n_irq = 0;
            for (int i = 0; i < N; i++) n_irq[i] = m_pend[i] && m_mask[i];
            if (req) begin
                case (off)
                    0: m_dat = pack_arr(m_pend);
                    1: m_dat = pack_arr(m_mask);
                    2: m_dat = pack_arr(m_edge);
                    4: m_dat = pack_arr(m_sq);
                    default: m_dat = 0;
                endcase
            end
            for (int i = 0; i < N; i++) begin
                wr_bit = req && wb_we && off < 6 && wb_dat[i] && wb_sel[i / 8];
                evt = m_edge[i] ? (m_sq[i] && !m_sd[i]) : m_sq[i];
                if (evt || (wr_bit && off == 5)) n_pend[i] = 1;
                else if (wr_bit && off == 3)     n_pend[i] = 0;
                else                             n_pend[i] = m_pend[i];
                n_mask[i] = (req && wb_we && off == 1 && wb_sel[i / 8]) ? wb_dat[i] : m_mask[i];
                n_edge[i] = (req && wb_we && off == 2 && wb_sel[i / 8]) ? wb_dat[i] : m_edge[i];
            end
            for (int i = 0; i < N; i++) begin
                m_pend[i] = n_pend[i];
                m_mask[i] = n_mask[i];
                m_edge[i] = n_edge[i];
                m_sd[i]   = m_sq[i];
                m_sq[i]   = src[i];
            end
            m_irq = n_irq;
            m_any = (n_irq != 0);
            m_ack = req && off < 6;
            m_err = req && off >= 6;
        end
    end

    // ---------------------------------------------------------------- compare
    always @(negedge clk) begin
        bit ok;
        ok = (irq_o === m_irq) && (irq_any_o === m_any) && (wb_ack_o === m_ack) &&
             (wb_err_o === m_err) && (wb_rty_o === 1'b0);
        if ((m_ack || m_err) && wb_dat_o !== m_dat) ok = 0;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL cycle_cmp t=%0t: irq=%h any=%b ack=%b err=%b dat=%h ; expected irq=%h any=%b ack=%b err=%b dat=%h",
                     $time, irq_o, irq_any_o, wb_ack_o, wb_err_o, wb_dat_o,
                     m_irq, m_any, m_ack, m_err, m_dat);
        end
    end

    // ---------------------------------------------------------------- driver tasks
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output logic [31:0] rd,
                        output logic got_ack, output logic got_err);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
        wb_adr = adr; wb_dat = dat; wb_sel = sel;
        rd = '0; got_ack = 1'b0; got_err = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (wb_ack_o || wb_err_o) begin
                got_ack = wb_ack_o; got_err = wb_err_o; rd = wb_dat_o;
                break;
            end
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        if (!got_ack && !got_err) begin
            tests++; fails++;
            $display("FAIL bus_timeout: adr=%h got no ack or err within 4 cycles", adr);
        end
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] rd; logic a, e;
        xfer(1'b1, adr, dat, sel, rd, a, e);
    endtask

    task automatic rd_reg(input logic [31:0] adr, output logic [31:0] data);
        logic a, e;
        xfer(1'b0, adr, 32'h0, 4'hF, data, a, e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        logic [31:0] v;
        logic a, e;

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset values.
        check("rst_irq", irq_o, 32'h0);
        rd_reg(32'h04, v); check("rst_mask", v, 32'h0);
        rd_reg(32'h08, v); check("rst_edge", v, 32'h3F);
        rd_reg(32'h00, v); check("rst_pend", v, 32'h0);

        // A one-cycle pulse on src2 in edge mode reaches irq_o two edges
        // after it is captured.
        wr(32'h04, 32'h3F, 4'hF);
        @(negedge clk); src[2] = 1'b1;
        @(negedge clk); src[2] = 1'b0;          // edge k has captured it
        check("pulse_k0", irq_o, 32'h0);
        @(negedge clk); check("pulse_k1", irq_o, 32'h0);
        @(negedge clk); check("pulse_k2", irq_o, 32'h04);
        check("pulse_any", {31'h0, irq_any_o}, 32'h1);

        // A source held high for 100 cycles gives no new trigger after CLR.
        src[2] = 1'b1;
        idle(100);
        rd_reg(32'h00, v); check("hold_pend", v, 32'h04);
        wr(32'h0C, 32'h04, 4'hF);
        idle(5);
        rd_reg(32'h00, v); check("hold_no_retrig", v, 32'h0);
        src[2] = 1'b0;
        idle(3);

        // Level mode: a bit cannot stay cleared while its source is high.
        wr(32'h08, 32'h00, 4'hF);
        wr(32'h04, 32'h01, 4'hF);
        src[0] = 1'b1;
        idle(3);
        wr(32'h0C, 32'h01, 4'hF);
        rd_reg(32'h00, v); check("level_reassert", v, 32'h01);
        src[0] = 1'b0;
        idle(3);
        wr(32'h0C, 32'h01, 4'hF);
        rd_reg(32'h00, v); check("level_cleared", v, 32'h0);
        check("level_irq", irq_o, 32'h0);
        wr(32'h08, 32'h3F, 4'hF);

        // A masked source still goes pending. Unmasking shows it one cycle
        // after the ack.
        wr(32'h04, 32'h00, 4'hF);
        @(negedge clk); src[4] = 1'b1;
        @(negedge clk); src[4] = 1'b0;
        idle(3);
        rd_reg(32'h00, v); check("masked_pend", v, 32'h10);
        check("masked_irq", irq_o, 32'h0);
        wr(32'h04, 32'h10, 4'hF);
        check("unmask_at_ack", irq_o, 32'h0);
        @(negedge clk); check("unmask_k1", irq_o, 32'h10);
        wr(32'h0C, 32'h10, 4'hF);

        // An event on the same edge as a CLR commit leaves the bit set.
        @(negedge clk); src[1] = 1'b1;
        wr(32'h0C, 32'h02, 4'hF);
        src[1] = 1'b0;
        rd_reg(32'h00, v); check("evt_beats_clr", v, 32'h02);
        wr(32'h0C, 32'h02, 4'hF);
        wr(32'h14, 32'h20, 4'b0000);
        rd_reg(32'h00, v); check("set_sel0", v, 32'h0);
        wr(32'h14, 32'h20, 4'b0001);
        rd_reg(32'h00, v); check("set_sel1", v, 32'h20);

        // Unmapped offsets return err, not ack, and have no side effects.
        xfer(1'b0, 32'h1C, 32'h0, 4'hF, v, a, e);
        check("unmapped_err", {30'h0, a, e}, 32'h1);
        check("unmapped_dat", v, 32'h0);
        xfer(1'b1, 32'h18, 32'h3F, 4'hF, v, a, e);
        check("unmapped_wr_err", {30'h0, a, e}, 32'h1);
        rd_reg(32'h04, v); check("unmapped_no_effect", v, 32'h10);

        // Reset during a pending MASK write aborts the write and gives no ack.
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
        wb_adr = 32'h04; wb_dat = 32'h3F; wb_sel = 4'hF;
        rst = 1'b1;
        @(negedge clk);
        check("rst_abort_ack", {31'h0, wb_ack_o}, 32'h0);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        rst = 1'b0;
        rd_reg(32'h04, v); check("rst_abort_mask", v, 32'h0);

        // Randomized phase. The compare process checks every cycle.
        for (int it = 0; it < 400; it++) begin
            logic [31:0] rdv;
            int op;
            src = N'($urandom_range(0, 63));
            op  = $urandom_range(0, 7);
            xfer(1'($urandom_range(0, 1)), {27'h0, 3'(op), 2'b00},
                 $urandom, 4'($urandom_range(0, 15)), rdv, a, e);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                if ($urandom_range(0, 1) == 1) src = N'($urandom_range(0, 63));
            end
        end
        src = '0;
        idle(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
